// File: rtl/nfca_rx_sched_pkg.sv
// nfca_rx_sched_pkg: FSM state encoding, frame status codes and end-status resolution.
package nfca_rx_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_GUARD, S_LISTEN, S_RECV, S_FLUSH, S_DONE} state_e;
  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_TIMEOUT   = 3'd1;
  localparam logic [2:0] ST_COLLISION = 3'd2;
  localparam logic [2:0] ST_ERROR     = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_OVERFLOW  = 3'd5;
  localparam logic [2:0] ST_ABORT     = 3'd6;
  function automatic logic [2:0] end_code(input logic col, input logic err);
    return col ? ST_COLLISION : err ? ST_ERROR : ST_OK;
  endfunction
endpackage

// File: rtl/nfca_rx_sched_if.sv
// nfca_rx_sched_if: controller/parser-facing signals of the receive scheduler; slave = scheduler side.
interface nfca_rx_sched_if;
  logic        i_start, i_abort, i_rx_bit_en, i_rx_bit, i_rx_end, i_rx_end_col, i_rx_end_err;
  logic        o_rx_on, o_busy, o_byte_en, o_done;
  logic [7:0]  o_byte;
  logic [3:0]  o_byte_bits;
  logic [2:0]  o_status;
  logic [11:0] o_bit_count;
  modport slave (
    input  i_start, i_abort, i_rx_bit_en, i_rx_bit, i_rx_end, i_rx_end_col, i_rx_end_err,
    output o_rx_on, o_busy, o_byte_en, o_done, o_byte, o_byte_bits, o_status, o_bit_count
  );
  modport master (
    output i_start, i_abort, i_rx_bit_en, i_rx_bit, i_rx_end, i_rx_end_col, i_rx_end_err,
    input  o_rx_on, o_busy, o_byte_en, o_done, o_byte, o_byte_bits, o_status, o_bit_count
  );
endinterface

// File: rtl/nfca_rx_bytepack.sv
// nfca_rx_bytepack: LSB-first packer, 8 data + 1 parity slots per byte, partial-byte flush.
// NFCA_RX_PARITY_CHECK_EN enables odd-parity checking of the 9th slot (sticky error).
module nfca_rx_bytepack (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic        i_bit,
  input  logic        i_flush,
  output logic        o_byte_en,
  output logic [7:0]  o_byte,
  output logic [3:0]  o_byte_bits,
  output logic [7:0]  o_bytes,
  output logic [11:0] o_bit_count,
  output logic        o_par_err
);
  logic [7:0]  r_sr, w_sr, r_byte, r_bytes;
  logic [3:0]  r_slot, w_slot, r_byte_bits;
  logic [11:0] r_bit_count;
  logic        r_byte_en, w_data, w_full, w_part;
  assign w_data = i_push && r_slot != 4'd8;
  assign w_full = i_push && r_slot == 4'd8;
  assign w_slot = w_data ? r_slot + 4'd1 : w_full ? 4'd0 : r_slot;
  // A flush in the same cycle as a data bit emits the byte including that bit.
  assign w_part = i_flush && w_slot != 4'd0;
  always_comb begin
    w_sr = r_sr;
    if (w_data) w_sr[r_slot[2:0]] = i_bit;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sr        <= '0;
      r_slot      <= '0;
      r_byte_en   <= 1'b0;
      r_byte      <= '0;
      r_byte_bits <= '0;
      r_bytes     <= '0;
      r_bit_count <= '0;
    end else begin
      r_byte_en <= w_full || w_part;
      if (w_full || w_part) begin
        r_byte      <= w_full ? r_sr : w_sr;
        r_byte_bits <= w_full ? 4'd8 : w_slot;
      end
      r_sr        <= (i_clr || w_full || i_flush) ? 8'd0 : w_sr;
      r_slot      <= (i_clr || i_flush) ? 4'd0 : w_slot;
      r_bytes     <= i_clr ? 8'd0 : r_bytes + {7'd0, w_full};
      r_bit_count <= i_clr ? 12'd0 : r_bit_count + {11'd0, w_data && r_bit_count != 12'hfff};
    end
`ifdef NFCA_RX_PARITY_CHECK_EN
  logic r_x, r_par_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_x       <= 1'b0;
      r_par_err <= 1'b0;
    end else if (i_clr) begin
      r_x       <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_x <= (w_full || i_flush) ? 1'b0 : r_x ^ (w_data && i_bit);
      if (w_full && r_x == i_bit) r_par_err <= 1'b1;
    end
  assign o_par_err = r_par_err;
`else
  assign o_par_err = 1'b0;
`endif
  assign o_byte_en   = r_byte_en;
  assign o_byte      = r_byte;
  assign o_byte_bits = r_byte_bits;
  assign o_bytes     = r_bytes;
  assign o_bit_count = r_bit_count;
endmodule

// File: rtl/nfca_rx_sched.sv
// nfca_rx_sched: ISO14443A PICC-response receive window: guard, listen with timeout, packing, status.
// Define NFCA_RX_PARITY_CHECK_EN to report odd-parity mismatches as PARITY status.
module nfca_rx_sched
  import nfca_rx_sched_pkg::*;
#(
  parameter logic [15:0] GUARD_CYCLES   = 16'd6000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd814000,
  parameter logic [7:0]  MAX_BYTES      = 8'd64
) (
  input logic            clk,
  input logic            rst,
  nfca_rx_sched_if.slave bus
);
  state_e      r_state;
  logic [23:0] r_cnt;
  logic [2:0]  r_cause, r_status, w_cause;
  logic [11:0] r_bit_count, w_bit_total;
  logic [7:0]  w_bytes;
  logic        r_rx_on, r_busy, r_done;
  logic        w_live, w_abort, w_ovf, w_end, w_timeout, w_flush, w_par_err;
  assign w_live    = r_state == S_LISTEN || r_state == S_RECV;
  assign w_abort   = bus.i_abort && (w_live || r_state == S_GUARD);
  assign w_ovf     = r_state == S_RECV && bus.i_rx_bit_en && w_bytes >= MAX_BYTES;
  assign w_end     = w_live && bus.i_rx_end;
  // Leaves LISTEN as the counter reaches TIMEOUT_CYCLES-1, so done lands TIMEOUT_CYCLES after entry.
  assign w_timeout = r_state == S_LISTEN && !bus.i_rx_bit_en && r_cnt + 24'd1 >= TIMEOUT_CYCLES - 24'd1;
  assign w_flush   = w_abort || w_ovf || w_end || w_timeout;
  assign w_cause   = w_abort ? ST_ABORT : w_ovf ? ST_OVERFLOW :
                     w_end ? end_code(bus.i_rx_end_col, bus.i_rx_end_err) : ST_TIMEOUT;
  nfca_rx_bytepack u_pack (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state == S_IDLE && bus.i_start),
    .i_push      (w_live && bus.i_rx_bit_en && !w_ovf),
    .i_bit       (bus.i_rx_bit),
    .i_flush     (w_flush),
    .o_byte_en   (bus.o_byte_en),
    .o_byte      (bus.o_byte),
    .o_byte_bits (bus.o_byte_bits),
    .o_bytes     (w_bytes),
    .o_bit_count (w_bit_total),
    .o_par_err   (w_par_err)
  );
  // PARITY is resolved in FLUSH so a parity bit arriving with rx_end is still seen.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rx_on     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cause     <= ST_OK;
      r_status    <= ST_OK;
      r_bit_count <= '0;
    end else if (w_flush) begin
      r_state <= S_FLUSH;
      r_cause <= w_cause;
      r_rx_on <= 1'b0;
    end else
      case (r_state)
        S_IDLE:
          if (bus.i_start) begin
            r_state <= S_GUARD;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        S_GUARD:
          if (r_cnt == {8'd0, GUARD_CYCLES} - 24'd1) begin
            r_state <= S_LISTEN;
            r_cnt   <= '0;
            r_rx_on <= 1'b1;
          end else r_cnt <= r_cnt + 24'd1;
        S_LISTEN, S_RECV: begin
          if (bus.i_rx_bit_en) r_state <= S_RECV;
          r_cnt <= r_cnt + 24'd1;
        end
        S_FLUSH: begin
          r_state     <= S_DONE;
          r_done      <= 1'b1;
          r_status    <= (r_cause == ST_OK && w_par_err) ? ST_PARITY : r_cause;
          r_bit_count <= w_bit_total;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
  assign bus.o_rx_on     = r_rx_on;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_status    = r_status;
  assign bus.o_bit_count = r_bit_count;
endmodule

// File: tb/tb_nfca_rx_sched.sv
// tb_nfca_rx_sched: directed vectors for nfca_rx_sched (GUARD=10, TIMEOUT=50, MAX_BYTES=2).
module tb_nfca_rx_sched;
`ifdef NFCA_RX_PARITY_CHECK_EN
  localparam logic [2:0] PAR_EXP = 3'd4;
`else
  localparam logic [2:0] PAR_EXP = 3'd0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int n_vec = 0, n_err = 0, cyc = 0, n_done = 0, be_cyc = 0, d_cyc = 0, e_cyc = 0, b_cyc = 0, lat = 0, t = 0, n0 = 0;
  logic [2:0] d_status = '0;
  logic [11:0] d_bits = '0;
  logic [11:0] be_q[$];
  always #5 clk = ~clk;
  nfca_rx_sched_if bus ();
  nfca_rx_sched #(.GUARD_CYCLES(16'd10), .TIMEOUT_CYCLES(24'd50), .MAX_BYTES(8'd2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always @(negedge clk) begin
    cyc++;
    if (bus.o_byte_en) begin
      be_q.push_back({bus.o_byte_bits, bus.o_byte});
      be_cyc = cyc;
    end
    if (bus.o_done) begin
      n_done++;
      d_status = bus.o_status;
      d_bits   = bus.o_bit_count;
      d_cyc    = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] qat(input int i);
    return i < be_q.size() ? be_q[i] : 12'hfff;
  endfunction
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic open_win();
    be_q.delete();
    step();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    lat = 1;
    while (!bus.o_rx_on && lat < 200) begin
      step();
      lat++;
    end
  endtask
  task automatic send_bits(input logic [17:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.i_rx_bit_en = 1'b1;
      bus.i_rx_bit    = v[i];
      b_cyc = cyc;
      step();
      bus.i_rx_bit_en = 1'b0;
      repeat (gap - 1) step();
    end
  endtask
  task automatic end_frame(input logic col, input logic err, input logic ab);
    bus.i_rx_end     = 1'b1;
    bus.i_rx_end_col = col;
    bus.i_rx_end_err = err;
    bus.i_abort      = ab;
    e_cyc = cyc;
    step();
    {bus.i_rx_end, bus.i_rx_end_col, bus.i_rx_end_err, bus.i_abort} = '0;
  endtask
  task automatic wait_done();
    n0 = n_done;
    t  = 0;
    while (n_done == n0 && t < 400) begin
      step();
      t++;
    end
    chk("done_seen", n_done - n0, 1);
  endtask
  initial begin
    {bus.i_start, bus.i_abort, bus.i_rx_bit_en, bus.i_rx_bit, bus.i_rx_end, bus.i_rx_end_col, bus.i_rx_end_err} = '0;
    repeat (3) step();
    chk("rst_outs", {bus.o_rx_on, bus.o_busy, bus.o_byte_en, bus.o_done, bus.o_status, bus.o_byte,
                     bus.o_byte_bits, bus.o_bit_count}, 0);
    rst = 1'b0;
    step();
    open_win();
    chk("t1_rx_on_lat", lat, 11);
    chk("t1_busy", bus.o_busy, 1);
    send_bits({2'b0, 7'h55, 1'b1, 8'h93}, 16, 24);
    end_frame(1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t1_nbytes", be_q.size(), 2);
    chk("t1_byte0", qat(0), {4'd8, 8'h93});
    chk("t1_byte1", qat(1), {4'd7, 8'h55});
    chk("t1_status", d_status, 0);
    chk("t1_bit_count", d_bits, 15);
    chk("t1_end_lat", d_cyc - e_cyc, 2);
    chk("t1_flush_lat", d_cyc - be_cyc, 1);
    open_win();
    wait_done();
    chk("t2_timeout_lat", t, 50);
    chk("t2_status", d_status, 1);
    chk("t2_nbytes", be_q.size(), 0);
    chk("t2_rx_on", bus.o_rx_on, 0);
    step();
    chk("t2_busy", bus.o_busy, 0);
    open_win();
    send_bits(18'h16, 5, 3);
    end_frame(1'b1, 1'b1, 1'b0);
    wait_done();
    chk("t3_nbytes", be_q.size(), 1);
    chk("t3_byte0", qat(0), {4'd5, 8'h16});
    chk("t3_status", d_status, 2);
    chk("t3_bit_count", d_bits, 5);
    open_win();
    end_frame(1'b0, 1'b1, 1'b0);
    wait_done();
    chk("t3b_status", d_status, 3);
    chk("t3b_nbytes", be_q.size(), 0);
    chk("t3b_bit_count", d_bits, 0);
    open_win();
    send_bits(18'h101, 9, 24);
    chk("t4_byte_lat", be_cyc - b_cyc, 1);
    end_frame(1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t4_nbytes", be_q.size(), 1);
    chk("t4_byte0", qat(0), {4'd8, 8'h01});
    chk("t4_status", d_status, PAR_EXP);
    chk("t4_bit_count", d_bits, 8);
    open_win();
    send_bits(18'h5, 3, 2);
    end_frame(1'b0, 1'b0, 1'b1);
    wait_done();
    chk("t5_nbytes", be_q.size(), 1);
    chk("t5_byte0", qat(0), {4'd3, 8'h05});
    chk("t5_status", d_status, 6);
    chk("t5_bit_count", d_bits, 3);
    open_win();
    send_bits(18'hC3, 8, 2);
    end_frame(1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t6_byte0", qat(0), {4'd8, 8'hC3});
    chk("t6_status", d_status, 0);
    chk("t6_bit_count", d_bits, 8);
    open_win();
    bus.i_rx_bit_en = 1'b1;
    bus.i_rx_bit    = 1'b1;
    end_frame(1'b0, 1'b0, 1'b0);
    bus.i_rx_bit_en = 1'b0;
    wait_done();
    chk("t7_byte0", qat(0), {4'd1, 8'h01});
    chk("t7_status", d_status, 0);
    chk("t7_bit_count", d_bits, 1);
    chk("t7_end_lat", d_cyc - e_cyc, 2);
    open_win();
    send_bits({1'b1, 8'h3C, 1'b1, 8'hA5}, 18, 2);
    send_bits(18'h1, 1, 1);
    wait_done();
    chk("t8_nbytes", be_q.size(), 2);
    chk("t8_byte0", qat(0), {4'd8, 8'hA5});
    chk("t8_byte1", qat(1), {4'd8, 8'h3C});
    chk("t8_status", d_status, 5);
    chk("t8_bit_count", d_bits, 16);
    chk("t8_ovf_lat", d_cyc - b_cyc, 2);
    step();
    n0 = n_done;
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    repeat (3) step();
    chk("t9_idle_abort_busy", bus.o_busy, 0);
    chk("t9_idle_abort_done", n_done - n0, 0);
    n0 = n_done;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    repeat (4) step();
    chk("t10_guard_busy", bus.o_busy, 1);
    rst = 1'b1;
    step();
    chk("t10_rst_outs", {bus.o_rx_on, bus.o_busy, bus.o_byte_en, bus.o_done, bus.o_status, bus.o_byte,
                         bus.o_byte_bits, bus.o_bit_count}, 0);
    rst = 1'b0;
    repeat (80) step();
    chk("t10_no_done", n_done - n0, 0);
    chk("t10_idle", {bus.o_rx_on, bus.o_busy}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
